// File: rtl/mdr_mem_pkg.sv
// Shared types and default sizing for the MDR/MAR memory interface unit.
// The optional timeout feature is selected with the MDR_MEM_TIMEOUT_EN macro.
package mdr_mem_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 9;
    localparam int DEF_TIMEOUT = 15;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/mdr_mem_wait_ctr.sv
// Ack wait counter for mdr_mem_unit; exists only when MDR_MEM_TIMEOUT_EN is defined.
// expired is high during the TIMEOUT-th consecutive request cycle without an ack.
`ifdef MDR_MEM_TIMEOUT_EN
module mdr_mem_wait_ctr #(
    parameter int TIMEOUT = mdr_mem_pkg::DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic ack,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    // Held at zero outside an access, so it is already clear on entering READ/WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!active) begin
            cnt <= '0;
        end else if (!ack) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (cnt == CW'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/mdr_mem_unit.sv
// Memory address/data register pair with a small read/write handshake FSM.
// Define MDR_MEM_TIMEOUT_EN to enable the ack timeout (ERR state and error pulse).
module mdr_mem_unit
    import mdr_mem_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mar_in,
    input  logic              mdr_in,
    input  logic              rd_start,
    input  logic              wr_start,
    output logic [DATA_W-1:0] mdr_q,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mar_q;
    logic [DATA_W-1:0] mdr_r;
    logic              timeout;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rd_start)      state_d = READ;
                else if (wr_start) state_d = WRITE;
            end
            READ, WRITE: begin
                if (mem_ack)      state_d = DONE;
                else if (timeout) state_d = ERR;
            end
            DONE, ERR: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // A start in the same cycle as mar_in must address the old MAR, so the load is skipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mar_q <= '0;
            mdr_r <= '0;
        end else if (state_q == IDLE) begin
            if (mar_in && !(rd_start || wr_start)) mar_q <= bus_in[ADDR_W-1:0];
            if (mdr_in)                            mdr_r <= bus_in;
        end else if (state_q == READ && mem_ack) begin
            mdr_r <= mem_rdata;
        end
    end

    assign busy      = (state_q == READ) || (state_q == WRITE);
    assign done      = (state_q == DONE);
    assign mem_req   = busy;
    assign mem_we    = (state_q == WRITE);
    assign mem_addr  = mar_q;
    assign mdr_q     = mdr_r;
    assign mem_wdata = mdr_r;

`ifdef MDR_MEM_TIMEOUT_EN
    logic expired;

    mdr_mem_wait_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .active  (busy),
        .ack     (mem_ack),
        .expired (expired)
    );

    assign timeout = expired;
    assign error   = (state_q == ERR);
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign timeout        = 1'b0;
    assign error          = 1'b0;
`endif

endmodule

// File: tb/tb_mdr_mem_unit.sv
// Self-checking bench for mdr_mem_unit: directed scenarios plus randomized accesses
// against a transaction-level model (register values and a memory array).
module tb_mdr_mem_unit;

    localparam int DW = 32;
    localparam int AW = 9;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] bus_in;
    logic          mar_in, mdr_in, rd_start, wr_start;
    logic [DW-1:0] mdr_q, mem_wdata, mem_rdata;
    logic          busy, done, error, mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;

    int checks = 0;
    int errors = 0;

    // Model: what MAR/MDR should hold and what the memory contains.
    logic [DW-1:0] model_mem [2**AW];
    logic [AW-1:0] exp_mar;
    logic [DW-1:0] exp_mdr;

    mdr_mem_unit #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_in    (bus_in),
        .mar_in    (mar_in),
        .mdr_in    (mdr_in),
        .rd_start  (rd_start),
        .wr_start  (wr_start),
        .mdr_q     (mdr_q),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .mem_addr  (mem_addr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus_in = '0; mar_in = 0; mdr_in = 0; rd_start = 0; wr_start = 0;
        mem_ack = 0; mem_rdata = '0;
    endtask

    task automatic idle_load(input bit lm, input bit ld, input logic [DW-1:0] v);
        mar_in = lm; mdr_in = ld; bus_in = v;
        tick;
        mar_in = 0; mdr_in = 0;
        if (lm) exp_mar = v[AW-1:0];
        if (ld) exp_mdr = v;
        checks++;
        if (mem_addr !== exp_mar || mdr_q !== exp_mdr) begin
            errors++;
            $display("FAIL idle_load: addr %h mdr %h, expected addr %h mdr %h", mem_addr, mdr_q, exp_mar, exp_mdr);
        end
    endtask

    // One full access: start, ack in request cycle ack_cyc, done pulse, back to idle.
    task automatic access(input bit rd, input bit wr, input bit lm, input bit ld,
                          input logic [DW-1:0] v, input int ack_cyc, input bit junk);
        bit is_rd;
        is_rd = rd;
        if (ld) exp_mdr = v;
        rd_start = rd; wr_start = wr; mar_in = lm; mdr_in = ld; bus_in = v;
        tick;
        rd_start = 0; wr_start = 0; mar_in = 0; mdr_in = 0;
        for (int c = 1; c <= ack_cyc; c++) begin
            checks++;
            if ({mem_req, busy, mem_we, done, error} !== {1'b1, 1'b1, ~is_rd, 1'b0, 1'b0} ||
                mem_addr !== exp_mar || mem_wdata !== exp_mdr) begin
                errors++;
                $display("FAIL access_req cyc %0d: req/busy/we/done/err %b addr %h wdata %h, expected %b addr %h wdata %h",
                         c, {mem_req, busy, mem_we, done, error}, mem_addr, mem_wdata,
                         {1'b1, 1'b1, ~is_rd, 1'b0, 1'b0}, exp_mar, exp_mdr);
            end
            if (junk) begin
                wr_start = 1; rd_start = 1'($urandom); mdr_in = 1; mar_in = 1; bus_in = $urandom;
            end
            if (c == ack_cyc) begin
                mem_ack = 1;
                mem_rdata = is_rd ? model_mem[exp_mar] : $urandom;
            end
            tick;
            clear_inputs;
        end
        if (is_rd) exp_mdr = model_mem[exp_mar];
        else       model_mem[exp_mar] = exp_mdr;
        checks++;
        if ({mem_req, busy, mem_we, done, error} !== 5'b00010 || mdr_q !== exp_mdr) begin
            errors++;
            $display("FAIL access_done: req/busy/we/done/err %b mdr %h, expected 00010 mdr %h",
                     {mem_req, busy, mem_we, done, error}, mdr_q, exp_mdr);
        end
        // Ack and starts during DONE must be ignored.
        mem_ack = 1; mem_rdata = $urandom; rd_start = junk; wr_start = junk; mdr_in = junk; bus_in = $urandom;
        tick;
        clear_inputs;
        checks++;
        if ({mem_req, busy, mem_we, done, error} !== 5'b00000 || mdr_q !== exp_mdr || mem_addr !== exp_mar) begin
            errors++;
            $display("FAIL access_idle: req/busy/we/done/err %b mdr %h addr %h, expected 00000 mdr %h addr %h",
                     {mem_req, busy, mem_we, done, error}, mdr_q, mem_addr, exp_mdr, exp_mar);
        end
    endtask

    task automatic test_reset;
        rst_n = 0;
        clear_inputs;
        exp_mar = '0; exp_mdr = '0;
        #3;
        checks++;
        if ({mem_req, busy, mem_we, done, error} !== 5'b0 || mdr_q !== '0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL reset_initial: flags %b mdr %h addr %h, expected all zero",
                     {mem_req, busy, mem_we, done, error}, mdr_q, mem_addr);
        end
        tick; tick;
        rst_n = 1;
        tick;
        idle_load(1, 1, $urandom | 32'h0000_0101);
        rd_start = 1;
        tick;
        rd_start = 0;
        tick;
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_read: mem_req %b, expected 1", mem_req);
        end
        mem_ack = 1; mem_rdata = $urandom | 32'h1;
        #2;
        rst_n = 0;
        #1;
        exp_mar = '0; exp_mdr = '0;
        checks++;
        if ({mem_req, busy, mem_we, done, error} !== 5'b0 || mdr_q !== '0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL reset_mid_read: flags %b mdr %h addr %h, expected all zero",
                     {mem_req, busy, mem_we, done, error}, mdr_q, mem_addr);
        end
        tick;
        mem_ack = 0;
        tick;
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if ({mem_req, busy, done, error} !== 4'b0 || mdr_q !== '0) begin
                errors++;
                $display("FAIL reset_after: flags %b mdr %h, expected 0000 mdr 0",
                         {mem_req, busy, done, error}, mdr_q);
            end
        end
    endtask

    task automatic test_read;
        idle_load(1, 0, 32'h0000_0005);
        model_mem[5] = 32'hDEAD_BEEF;
        access(1, 0, 0, 0, '0, 3, 0);
        checks++;
        if (mem_addr !== 9'h005 || mdr_q !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL read_directed: addr %h mdr %h, expected 005 deadbeef", mem_addr, mdr_q);
        end
    endtask

    task automatic test_write;
        idle_load(0, 1, 32'h1234_5678);
        access(0, 1, 0, 0, '0, 2, 0);
        checks++;
        if (mdr_q !== 32'h1234_5678 || model_mem[5] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL write_directed: mdr %h, expected 12345678", mdr_q);
        end
    endtask

    task automatic test_priority;
        idle_load(1, 1, ($urandom & ~32'h1F0) | 32'h3);
        access(1, 1, 1, 1, $urandom, 2, 1);
        access(0, 1, 1, 1, $urandom, 3, 1);
        access(1, 0, 0, 0, '0, 1, 0);
    endtask

    task automatic test_timeout;
`ifdef MDR_MEM_TIMEOUT_EN
        for (int k = 0; k < 2; k++) begin
            rd_start = (k == 0); wr_start = (k == 1);
            tick;
            rd_start = 0; wr_start = 0;
            for (int c = 1; c <= TO; c++) begin
                checks++;
                if (mem_req !== 1'b1 || error !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_wait cyc %0d: req %b err %b done %b, expected 1 0 0", c, mem_req, error, done);
                end
                tick;
            end
            checks++;
            if ({mem_req, busy, mem_we, done, error} !== 5'b00001 || mdr_q !== exp_mdr) begin
                errors++;
                $display("FAIL timeout_err: flags %b mdr %h, expected 00001 mdr %h",
                         {mem_req, busy, mem_we, done, error}, mdr_q, exp_mdr);
            end
            mem_ack = 1; mem_rdata = $urandom;
            tick;
            mem_ack = 0;
            checks++;
            if ({mem_req, busy, mem_we, done, error} !== 5'b0 || mdr_q !== exp_mdr) begin
                errors++;
                $display("FAIL timeout_after: flags %b mdr %h, expected 00000 mdr %h",
                         {mem_req, busy, mem_we, done, error}, mdr_q, exp_mdr);
            end
        end
        access(1, 0, 0, 0, '0, TO, 0);
        access(0, 1, 0, 1, $urandom, TO, 0);
`else
        access(1, 0, 0, 0, '0, 40, 0);
        access(0, 1, 0, 1, $urandom, 40, 0);
`endif
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            bit rd, wr;
            if ($urandom_range(0, 1) == 1) idle_load(1, 1'($urandom_range(0, 1)), $urandom & ~32'h1F0);
            if ($urandom_range(0, 1) == 1) idle_load(0, 1, $urandom);
            rd = 1'($urandom_range(0, 1));
            wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            access(rd, wr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom & ~32'h1F0,
                   $urandom_range(1, 6), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        foreach (model_mem[i]) model_mem[i] = $urandom;
        test_reset;
        test_read;
        test_write;
        test_priority;
        test_timeout;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mdr_mem_unit.md
MDR_MEM_UNIT -- requirements
Module: mdr_mem_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, bus and memory data width.
REQ-002 SHALL have parameter ADDR_W, default 9, memory address width.
REQ-003 SHALL have parameter TIMEOUT, default 15, max cycles waiting for mem_ack.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  async active-low reset.
REQ-007 bus_in  input  DATA_W  shared bus value (bus mux output).
REQ-008 mar_in  input  1  load MAR from bus_in[ADDR_W-1:0].
REQ-009 mdr_in  input  1  load MDR from bus_in.
REQ-010 rd_start  input  1  start memory read at MAR.
REQ-011 wr_start  input  1  start memory write of MDR to MAR.
REQ-012 mdr_q  output  DATA_W  MDR contents; a bus mux data input.
REQ-013 busy  output  1  high in READ or WRITE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 error  output  1  one-cycle timeout pulse.
REQ-016 mem_addr  output  ADDR_W  MAR contents.
REQ-017 mem_req  output  1  memory request, held until ack or timeout.
REQ-018 mem_we  output  1  write qualifier, valid with mem_req.
REQ-019 mem_wdata  output  DATA_W  equals mdr_q.
REQ-020 mem_rdata  input  DATA_W  read data, valid with mem_ack.
REQ-021 mem_ack  input  1  one-cycle acknowledge.

Function
REQ-022 SHALL implement FSM states IDLE, READ, WRITE, DONE, ERR.
REQ-023 IDLE: rd_start -> READ; else wr_start -> WRITE; both high -> READ (read priority).
REQ-024 READ/WRITE: mem_req=1, mem_we=1 only in WRITE; mem_ack sampled high -> DONE; READ also loads MDR from mem_rdata on that edge.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE; ERR: error=1 for one cycle, then IDLE.
REQ-026 Latency: start at edge N -> mem_req high cycle N+1; ack at cycle N+k -> done high cycle N+k+1.
REQ-027 SHALL load MAR/MDR from bus_in only in IDLE; mar_in/mdr_in in other states ignored.
REQ-028 mdr_in with rd_start in IDLE: MDR loads bus_in; read result overwrites it on ack.
REQ-029 mar_in with rd_start/wr_start in IDLE: access uses the OLD MAR value.
REQ-030 rd_start/wr_start outside IDLE ignored; mem_ack outside READ/WRITE ignored.
REQ-031 Wait counter: clears on entering READ/WRITE, increments each cycle without ack.
REQ-032 Ack in same cycle counter reaches TIMEOUT-1 SHALL win over timeout (-> DONE).

Reset
REQ-033 rst_n low SHALL immediately force IDLE, MAR=0, MDR=0, counter=0; busy, done, error, mem_req, mem_we = 0.
REQ-034 Reset mid-access SHALL abort it with no done/error pulse; MDR=0 regardless of ack.

Configuration
REQ-035 With MDR_MEM_TIMEOUT_EN defined: READ/WRITE with no ack for TIMEOUT consecutive cycles -> ERR, MDR unchanged, mem_req drops.
REQ-036 Without MDR_MEM_TIMEOUT_EN: no counter, waits indefinitely for ack, ERR unreachable, error tied 0.

Structure
REQ-037 Shared package SHALL hold the FSM state enum type and default DATA_W/ADDR_W/TIMEOUT constants.
REQ-038 Sub-module mdr_mem_wait_ctr SHALL hold the wait counter, compiled only under MDR_MEM_TIMEOUT_EN.

Verification
REQ-039 Reset: rst_n low mid-READ -> all outputs 0, IDLE, no done.
REQ-040 Read: mar_in bus_in=0x0000_0005; rd_start; ack after 3 cycles with rdata=0xDEAD_BEEF -> mem_addr=5, mdr_q=0xDEAD_BEEF, done one cycle.
REQ-041 Write: mdr_in bus_in=0x1234_5678; wr_start; ack -> mem_we=1, mem_wdata=0x1234_5678 while req, done pulse.
REQ-042 Timeout (EN, TIMEOUT=15): rd_start, no ack -> error at 16th cycle after start, mdr_q unchanged; ack on 15th req cycle -> done instead.
REQ-043 rd_start+wr_start together -> read; wr_start/mdr_in during busy -> ignored, MDR intact.
